// File: rtl/hilo_move_unit.sv
// HI/LO special-register unit: mthi/mtlo/mfhi/mflo plus iterative mult/multu (optional div/divu under HILO_DIV_EN).
// Latency: moves 1 cycle (result registered); mult/div busy for WIDTH+1 cycles after accept, div-by-zero for 1 cycle.
// Backpressure: busy=1 while an iterative op runs; any op_valid seen while busy is dropped without effect.
module hilo_move_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic             op_signed_div,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MTHI  = 3'b001;
    localparam logic [2:0] OP_MTLO  = 3'b010;
    localparam logic [2:0] OP_MFHI  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MULT  = 3'b101;
    localparam logic [2:0] OP_MULTU = 3'b110;
`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b111;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef HILO_DIV_EN
        S_DIV  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    // acc: mult -> {upper partial sum (WIDTH+1), multiplier/low product (WIDTH)}
    //      div  -> {remainder (WIDTH+1), dividend/quotient (WIDTH)}
    logic [2*WIDTH:0]    acc;
    logic [WIDTH-1:0]    mcand;
    logic                neg_lo;
`ifdef HILO_DIV_EN
    logic                neg_hi;
    logic                is_div;
    logic [WIDTH+1:0]    div_diff;
    logic [WIDTH:0]      div_shift;
    logic [2*WIDTH:0]    div_next;
`else
    logic                unused_sd;
    assign unused_sd = op_signed_div;
`endif

    logic                accept;
    logic                sgn_op;
    logic [WIDTH-1:0]    rs_mag, rt_mag;
    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH:0]    mul_next;
    logic [2*WIDTH-1:0]  prod, prod_neg;

    assign accept = op_valid && (state == S_IDLE);
    assign busy   = (state != S_IDLE);

`ifdef HILO_DIV_EN
    assign sgn_op = (op == OP_MULT) || ((op == OP_DIV) && op_signed_div);
`else
    assign sgn_op = (op == OP_MULT);
`endif
    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    assign rs_mag = (sgn_op && rs[WIDTH-1]) ? -rs : rs;
    assign rt_mag = (sgn_op && rt[WIDTH-1]) ? -rt : rt;

    // One shift-add step: add multiplicand to the upper half when the current multiplier bit is set, then shift right.
    assign mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    assign mul_next = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};

    assign prod     = acc[2*WIDTH-1:0];
    assign prod_neg = -prod;

`ifdef HILO_DIV_EN
    // One restoring step: shift next dividend bit into the remainder, subtract divisor if it fits.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    assign div_next  = div_diff[WIDTH+1] ? {div_shift, acc[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: iterative ops run WIDTH steps, then one DONE cycle to commit HI/LO.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (op == OP_MULT || op == OP_MULTU)) state_nxt = S_MUL;
`ifdef HILO_DIV_EN
                if (accept && op == OP_DIV) state_nxt = (rt == '0) ? S_DONE : S_DIV;
`endif
            end
            S_MUL:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_DONE;
`ifdef HILO_DIV_EN
            S_DIV:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: moves, operand setup on accept, iteration, and HI/LO commit in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi           <= '0;
            lo           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            neg_lo       <= 1'b0;
`ifdef HILO_DIV_EN
            neg_hi       <= 1'b0;
            is_div       <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            OP_MFHI: begin result <= hi; result_valid <= 1'b1; end
                            OP_MFLO: begin result <= lo; result_valid <= 1'b1; end
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{(WIDTH+1){1'b0}}, rt_mag};
                                mcand  <= rs_mag;
                                neg_lo <= (op == OP_MULT) && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                                cnt    <= '0;
`ifdef HILO_DIV_EN
                                is_div <= 1'b0;
`endif
                            end
`ifdef HILO_DIV_EN
                            OP_DIV: begin
                                is_div <= 1'b1;
                                cnt    <= '0;
                                mcand  <= rt_mag;
                                if (rt == '0) begin
                                    // Divide by zero: preload remainder=rs, quotient=all ones.
                                    acc    <= {1'b0, rs, {WIDTH{1'b1}}};
                                    neg_lo <= 1'b0;
                                    neg_hi <= 1'b0;
                                end else begin
                                    acc    <= {{(WIDTH+1){1'b0}}, rs_mag};
                                    neg_lo <= op_signed_div && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                                    neg_hi <= op_signed_div && rs[WIDTH-1];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
`ifdef HILO_DIV_EN
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
`endif
                S_DONE: begin
                    cnt <= '0;
`ifdef HILO_DIV_EN
                    if (is_div) begin
                        lo <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= neg_lo ? prod_neg : prod;
                    end
`else
                    {hi, lo} <= neg_lo ? prod_neg : prod;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
